// File: rtl/axis_credit_gatekeeper.sv
// rtl/axis_credit_gatekeeper.sv - credit-gated AXI4-Stream throttle with optional skid slice
module axis_credit_gatekeeper #(
  parameter int C_AXIS_DATA_BYTES  = 8,
  parameter int C_AXIS_USE_TKEEP   = 0,
  parameter int C_AXIS_TUSER_WIDTH = 0,
  parameter int C_AXIS_USE_TLAST   = 0,
  parameter int C_COUNT_WIDTH      = 9,
  parameter int C_GRANT_WIDTH      = 4,
  parameter int C_MODE             = 0,
  parameter int C_REG_OUTPUT       = 1,
  localparam int DW = 8 * C_AXIS_DATA_BYTES,
  localparam int KW = C_AXIS_DATA_BYTES,
  localparam int UW = (C_AXIS_TUSER_WIDTH > 0) ? C_AXIS_TUSER_WIDTH : 1
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [DW-1:0]            s_axis_tdata,
  input  logic [KW-1:0]            s_axis_tkeep,
  input  logic [UW-1:0]            s_axis_tuser,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [DW-1:0]            m_axis_tdata,
  output logic [KW-1:0]            m_axis_tkeep,
  output logic [UW-1:0]            m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic                     s_grant_valid,
  input  logic [C_GRANT_WIDTH-1:0] s_grant_count,
  input  logic                     s_flush,
  output logic [C_COUNT_WIDTH-1:0] credit_count,
  output logic                     credit_overflow
);

  localparam int PW = DW + KW + UW + 1;
  localparam int SW = ((C_GRANT_WIDTH > C_COUNT_WIDTH) ? C_GRANT_WIDTH : C_COUNT_WIDTH) + 1;
  localparam logic [SW-1:0] MAX_COUNT = {{(SW - C_COUNT_WIDTH){1'b0}}, {C_COUNT_WIDTH{1'b1}}};

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_IN_PKT
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            eot;
  logic            gate_open;
  logic            slice_has_room;
  logic            accept;
  logic            consume;
  logic [SW-1:0]   grant_ext;
  logic [SW-1:0]   credit_sum;
  logic [KW-1:0]   tkeep_eff;
  logic [UW-1:0]   tuser_eff;
  logic            tlast_eff;
  logic [PW-1:0]   s_payload;
  logic [PW-1:0]   m_payload;

  assign eot       = (C_AXIS_USE_TLAST != 0) ? s_axis_tlast : 1'b1;
  assign gate_open = ((C_MODE == 0) && (state == ST_IN_PKT)) || (credit_count != '0);

  assign s_axis_tready = gate_open & slice_has_room;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign consume       = accept & ((C_MODE != 0) || (state == ST_IDLE));

  // Packet tracking only matters when credits are charged per packet
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if ((C_MODE == 0) && accept) begin
      if ((state == ST_IDLE) && !eot) begin
        state_next = ST_IN_PKT;
      end else if ((state == ST_IN_PKT) && eot) begin
        state_next = ST_IDLE;
      end
    end
  end

  // One extra bit of headroom lets saturation be detected before clipping
  always_comb begin
    grant_ext  = s_grant_valid ? SW'(s_grant_count) : '0;
    credit_sum = SW'(credit_count) + grant_ext - SW'(consume);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      credit_count    <= '0;
      credit_overflow <= 1'b0;
    end else if (s_flush) begin
      credit_count <= '0;
    end else if (credit_sum > MAX_COUNT) begin
      credit_count    <= '1;
      credit_overflow <= 1'b1;
    end else begin
      credit_count <= credit_sum[C_COUNT_WIDTH-1:0];
    end
  end

  assign tkeep_eff = (C_AXIS_USE_TKEEP != 0) ? s_axis_tkeep : '1;
  assign tuser_eff = (C_AXIS_TUSER_WIDTH > 0) ? s_axis_tuser : '0;
  assign tlast_eff = (C_AXIS_USE_TLAST != 0) ? s_axis_tlast : 1'b1;
  assign s_payload = {tuser_eff, tlast_eff, tkeep_eff, s_axis_tdata};
  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = m_payload;

  generate
    if (C_REG_OUTPUT != 0) begin : g_slice
      logic [PW-1:0] main_q;
      logic [PW-1:0] skid_q;
      logic          main_valid;
      logic          skid_valid;
      logic          pop;

      // Room depends only on the skid register, so ready never sees m_axis_tready
      assign slice_has_room = ~skid_valid;
      assign pop            = main_valid & m_axis_tready;
      assign m_axis_tvalid  = main_valid;
      assign m_payload      = main_q;

      always_ff @(posedge aclk) begin
        if (areset) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end else if (skid_valid) begin
          if (pop) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
          end
        end else if (accept) begin
          if (!main_valid || pop) begin
            main_q     <= s_payload;
            main_valid <= 1'b1;
          end else begin
            skid_q     <= s_payload;
            skid_valid <= 1'b1;
          end
        end else if (pop) begin
          main_valid <= 1'b0;
        end
      end
    end else begin : g_bypass
      assign slice_has_room = m_axis_tready;
      assign m_axis_tvalid  = s_axis_tvalid & gate_open;
      assign m_payload      = s_payload;
    end
  endgenerate

endmodule

// File: tb/tb_axis_credit_gatekeeper.sv
// tb/tb_axis_credit_gatekeeper.sv - directed and random scoreboard bench for axis_credit_gatekeeper
module tb_axis_credit_gatekeeper;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [1:0]  user;
    logic        last;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset;

  // u0: per-packet credits, tlast honoured, 4-bit counter, registered slice
  logic [63:0] s0_tdata;
  logic [7:0]  s0_tkeep;
  logic [1:0]  s0_tuser;
  logic        s0_tvalid, s0_tlast, s0_tready;
  logic [63:0] m0_tdata;
  logic [7:0]  m0_tkeep;
  logic [1:0]  m0_tuser;
  logic        m0_tlast, m0_tvalid, m0_tready;
  logic        g0_valid, f0, ov0;
  logic [3:0]  g0_count;
  logic [3:0]  cc0;

  // u1: per-beat credits, tlast honoured, pass-through output
  logic [63:0] s1_tdata;
  logic [7:0]  s1_tkeep;
  logic [0:0]  s1_tuser;
  logic        s1_tvalid, s1_tlast, s1_tready;
  logic [63:0] m1_tdata;
  logic [7:0]  m1_tkeep;
  logic [0:0]  m1_tuser;
  logic        m1_tlast, m1_tvalid, m1_tready;
  logic        g1_valid, f1, ov1;
  logic [3:0]  g1_count;
  logic [8:0]  cc1;

  int    n_cmp = 0;
  int    n_err = 0;
  logic  rdy0_s, rdy1_s;
  bit    rnd_on = 0;
  beat_t q0[$];
  beat_t q1[$];

  always #5 aclk = ~aclk;

  axis_credit_gatekeeper #(
    .C_AXIS_DATA_BYTES(8), .C_AXIS_USE_TKEEP(1), .C_AXIS_TUSER_WIDTH(2), .C_AXIS_USE_TLAST(1),
    .C_COUNT_WIDTH(4), .C_GRANT_WIDTH(4), .C_MODE(0), .C_REG_OUTPUT(1)
  ) u0 (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s0_tdata), .s_axis_tkeep(s0_tkeep), .s_axis_tuser(s0_tuser),
    .s_axis_tvalid(s0_tvalid), .s_axis_tlast(s0_tlast), .s_axis_tready(s0_tready),
    .m_axis_tdata(m0_tdata), .m_axis_tkeep(m0_tkeep), .m_axis_tuser(m0_tuser),
    .m_axis_tlast(m0_tlast), .m_axis_tvalid(m0_tvalid), .m_axis_tready(m0_tready),
    .s_grant_valid(g0_valid), .s_grant_count(g0_count), .s_flush(f0),
    .credit_count(cc0), .credit_overflow(ov0)
  );

  axis_credit_gatekeeper #(
    .C_AXIS_DATA_BYTES(8), .C_AXIS_USE_TKEEP(0), .C_AXIS_TUSER_WIDTH(0), .C_AXIS_USE_TLAST(1),
    .C_COUNT_WIDTH(9), .C_GRANT_WIDTH(4), .C_MODE(1), .C_REG_OUTPUT(0)
  ) u1 (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s1_tdata), .s_axis_tkeep(s1_tkeep), .s_axis_tuser(s1_tuser),
    .s_axis_tvalid(s1_tvalid), .s_axis_tlast(s1_tlast), .s_axis_tready(s1_tready),
    .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tuser(m1_tuser),
    .m_axis_tlast(m1_tlast), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
    .s_grant_valid(g1_valid), .s_grant_count(g1_count), .s_flush(f1),
    .credit_count(cc1), .credit_overflow(ov1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Negedge sampling point: scoreboard pops, plus the ready-independence probe in random mode
  task automatic sample();
    beat_t e;
    logic  t;
    @(negedge aclk);
    rdy0_s = s0_tready;
    rdy1_s = s1_tready;
    if (!areset && m0_tvalid && m0_tready) begin
      chk("m0_beat_expected", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("m0_tdata", m0_tdata, e.data);
        chk("m0_tkeep", 64'(m0_tkeep), 64'(e.keep));
        chk("m0_tuser", 64'(m0_tuser), 64'(e.user));
        chk("m0_tlast", 64'(m0_tlast), 64'(e.last));
      end
    end
    if (!areset && m1_tvalid && m1_tready) begin
      chk("m1_beat_expected", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("m1_tdata", m1_tdata, e.data);
        chk("m1_tkeep", 64'(m1_tkeep), 64'hFF);
        chk("m1_tuser", 64'(m1_tuser), 64'd0);
        chk("m1_tlast", 64'(m1_tlast), 64'(e.last));
      end
    end
    if (rnd_on) begin
      t = s0_tready;
      m0_tready = ~m0_tready;
      #1;
      chk("s0_tready_indep_of_m0_tready", 64'(s0_tready), 64'(t));
      m0_tready = ~m0_tready;
      #1;
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    if (rnd_on) m0_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic drv0(input logic [63:0] d, input logic [7:0] k, input logic [1:0] u, input logic l);
    bit ok = 0;
    q0.push_back(beat_t'{d, k, u, l});
    s0_tdata = d; s0_tkeep = k; s0_tuser = u; s0_tlast = l; s0_tvalid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      sample();
      ok = rdy0_s;
      step();
    end
    s0_tvalid = 1'b0;
    if (!ok) chk("s0_accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic drv1(input logic [63:0] d, input logic l);
    bit ok = 0;
    q1.push_back(beat_t'{d, 8'hFF, 2'b00, l});
    s1_tdata = d; s1_tkeep = 8'h0F; s1_tlast = l; s1_tvalid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      sample();
      ok = rdy1_s;
      step();
    end
    s1_tvalid = 1'b0;
    if (!ok) chk("s1_accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic grant0(input logic [3:0] n);
    g0_valid = 1'b1; g0_count = n;
    sample();
    step();
    g0_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++) begin
      sample();
      step();
    end
    chk({tag, "_q0_empty"}, 64'(q0.size()), 64'd0);
    chk({tag, "_q1_empty"}, 64'(q1.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    int plen;
    areset = 1'b1;
    s0_tdata = '0; s0_tkeep = '0; s0_tuser = '0; s0_tlast = 1'b0; s0_tvalid = 1'b1;
    s1_tdata = '0; s1_tkeep = '0; s1_tuser = '0; s1_tlast = 1'b0; s1_tvalid = 1'b1;
    m0_tready = 1'b1; m1_tready = 1'b1;
    g0_valid = 1'b0; g0_count = '0; f0 = 1'b0;
    g1_valid = 1'b0; g1_count = '0; f1 = 1'b0;

    // Reset state, with valid held high so the closed gate is observable
    repeat (3) step();
    sample();
    chk("rst_cc0", 64'(cc0), 64'd0);
    chk("rst_ov0", 64'(ov0), 64'd0);
    chk("rst_s0_tready", 64'(s0_tready), 64'd0);
    chk("rst_m0_tvalid", 64'(m0_tvalid), 64'd0);
    chk("rst_cc1", 64'(cc1), 64'd0);
    chk("rst_s1_tready", 64'(s1_tready), 64'd0);
    chk("rst_m1_tvalid", 64'(m1_tvalid), 64'd0);
    areset = 1'b0;
    step();
    sample();
    chk("post_rst_s0_tready", 64'(rdy0_s), 64'd0);
    s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    step();

    // Grant of 3, single-beat packets: exactly three pass, count 3,2,1,0
    g0_valid = 1'b1; g0_count = 4'd3;
    sample();
    chk("t1_cc_same_cycle", 64'(cc0), 64'd0);
    chk("t1_rdy_same_cycle", 64'(rdy0_s), 64'd0);
    step();
    g0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q0.push_back(beat_t'{64'hA000 + 64'(i), 8'hF0 | 8'(i), 2'(i), 1'b1});
      s0_tdata = 64'hA000 + 64'(i); s0_tkeep = 8'hF0 | 8'(i); s0_tuser = 2'(i);
      s0_tlast = 1'b1; s0_tvalid = 1'b1;
      sample();
      chk($sformatf("t1_cc_beat%0d", i), 64'(cc0), 64'(3 - i));
      chk($sformatf("t1_rdy_beat%0d", i), 64'(rdy0_s), 64'd1);
      if (i > 0) chk($sformatf("t1_m0_tvalid_next%0d", i), 64'(m0_tvalid), 64'd1);
      step();
    end
    s0_tdata = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t1_stall_rdy", 64'(rdy0_s), 64'd0);
      chk("t1_stall_cc", 64'(cc0), 64'd0);
      step();
    end
    s0_tvalid = 1'b0;
    drain("t1");

    // One credit, 5-beat packet, flush (with a discarded grant) on beat 2
    grant0(4'd1);
    drv0(64'hB001, 8'h01, 2'd1, 1'b0);
    f0 = 1'b1; g0_valid = 1'b1; g0_count = 4'd3;
    drv0(64'hB002, 8'h03, 2'd2, 1'b0);
    f0 = 1'b0; g0_valid = 1'b0;
    drv0(64'hB003, 8'h07, 2'd3, 1'b0);
    drv0(64'hB004, 8'h0F, 2'd0, 1'b0);
    drv0(64'hB005, 8'h1F, 2'd1, 1'b1);
    sample();
    chk("t2_cc_after_flush", 64'(cc0), 64'd0);
    step();
    s0_tdata = 64'hB100; s0_tlast = 1'b1; s0_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t2_next_pkt_stall", 64'(rdy0_s), 64'd0);
      step();
    end
    s0_tvalid = 1'b0;
    drain("t2");

    // Per-beat credits: grant 2 passes beats 1-2, beat 3 waits for the next grant
    g1_valid = 1'b1; g1_count = 4'd2;
    sample();
    step();
    g1_valid = 1'b0;
    drv1(64'hC001, 1'b0);
    drv1(64'hC002, 1'b0);
    s1_tdata = 64'hC003; s1_tlast = 1'b0; s1_tvalid = 1'b1;
    sample();
    chk("t3_stall_rdy", 64'(rdy1_s), 64'd0);
    chk("t3_stall_m1_tvalid", 64'(m1_tvalid), 64'd0);
    chk("t3_stall_cc", 64'(cc1), 64'd0);
    step();
    g1_valid = 1'b1; g1_count = 4'd2;
    sample();
    chk("t3_grant_cycle_rdy", 64'(rdy1_s), 64'd0);
    step();
    g1_valid = 1'b0;
    drv1(64'hC003, 1'b0);
    drv1(64'hC004, 1'b1);
    sample();
    chk("t3_cc_end", 64'(cc1), 64'd0);
    chk("t3_rdy_end", 64'(rdy1_s), 64'd0);
    step();
    drain("t3");

    // Saturation of the 4-bit counter: 14 + 5 clips to 15 and sets the sticky flag
    grant0(4'd14);
    sample();
    chk("t4_cc_14", 64'(cc0), 64'd14);
    chk("t4_ov_before", 64'(ov0), 64'd0);
    step();
    grant0(4'd5);
    sample();
    chk("t4_cc_sat", 64'(cc0), 64'd15);
    chk("t4_ov_set", 64'(ov0), 64'd1);
    step();
    grant0(4'd15);
    sample();
    chk("t4_cc_hold", 64'(cc0), 64'd15);
    step();
    f0 = 1'b1;
    step();
    f0 = 1'b0;
    sample();
    chk("t4_cc_flushed", 64'(cc0), 64'd0);
    chk("t4_ov_sticky", 64'(ov0), 64'd1);
    step();

    // Grant and first-beat consume in the same cycle net out; then reset with a full slice
    grant0(4'd1);
    m0_tready = 1'b0;
    g0_valid = 1'b1; g0_count = 4'd1;
    q0.push_back(beat_t'{64'hD001, 8'hAA, 2'd2, 1'b0});
    s0_tdata = 64'hD001; s0_tkeep = 8'hAA; s0_tuser = 2'd2; s0_tlast = 1'b0; s0_tvalid = 1'b1;
    sample();
    chk("t6_rdy_a", 64'(rdy0_s), 64'd1);
    step();
    g0_valid = 1'b0;
    q0.push_back(beat_t'{64'hD002, 8'h55, 2'd1, 1'b0});
    s0_tdata = 64'hD002; s0_tkeep = 8'h55; s0_tuser = 2'd1;
    sample();
    chk("t6_cc_net", 64'(cc0), 64'd1);
    chk("t6_rdy_b", 64'(rdy0_s), 64'd1);
    step();
    s0_tdata = 64'hD003;
    sample();
    chk("t6_full_rdy", 64'(rdy0_s), 64'd0);
    chk("t6_full_m0_tvalid", 64'(m0_tvalid), 64'd1);
    areset = 1'b1;
    step();
    areset = 1'b0;
    s0_tvalid = 1'b0;
    q0.delete();
    sample();
    chk("t6_rst_m0_tvalid", 64'(m0_tvalid), 64'd0);
    chk("t6_rst_s0_tready", 64'(s0_tready), 64'd0);
    chk("t6_rst_cc", 64'(cc0), 64'd0);
    chk("t6_rst_ov", 64'(ov0), 64'd0);
    step();
    m0_tready = 1'b1;

    // 1000 random beats under random backpressure with credits topped up per packet
    rnd_on = 1;
    beats = 0;
    while (beats < 1000) begin
      plen = int'($urandom_range(1, 4));
      if (cc0 < 4'd2) grant0(4'd10);
      for (int k = 0; k < plen; k++) begin
        drv0({$urandom, $urandom}, 8'($urandom), 2'($urandom), k == plen - 1);
        beats++;
      end
    end
    rnd_on = 0;
    m0_tready = 1'b1;
    drain("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
